multicycle_core_seq: RTL
========================

Name: multicycle_core_seq

Overview:
- Parametrised multi-cycle sequencer that replaces the free-running "PC+4 every clock" single-cycle flow of the core top.
- Owns the PC and the instruction register (IR).
- Drives valid/ready handshakes to instruction and data memories, which may stall.
- Sequences FETCH/DECODE/EXEC/MEM/WB and gates regfile writes and PC updates.
- Sits between the memories and the existing decode, regfile, ALU and writeback datapath.

Parameters:
- XLEN, 32, datapath and address width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset (XLEN bits).
- STATE_W, 3, width of the exported state code.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- imem_valid  out  1  instruction fetch request.
- imem_ready  in  1  fetch accepted and data valid this cycle.
- imem_addr  out  XLEN  fetch address, always equal to pc.
- imem_rdata  in  32  fetched instruction.
- dmem_valid  out  1  data access request.
- dmem_ready  in  1  data access complete this cycle.
- dmem_we  out  1  1 = store, 0 = load.
- dmem_addr  out  XLEN  data address, registered from alu_result.
- dmem_wdata  out  XLEN  store data, registered from rs2_data.
- dmem_rdata  in  XLEN  load data.
- dec_reg_write, dec_mem_read, dec_mem_write, dec_branch, dec_jump, dec_illegal  in  1 each  decoder class flags for the IR.
- branch_taken  in  1  comparator result.
- target_pc  in  XLEN  branch/jump target.
- alu_result  in  XLEN  ALU output.
- rs2_data  in  XLEN  regfile port 2.
- pc  out  XLEN  current PC.
- instr  out  32  IR.
- rd_wen  out  1  regfile write-enable pulse.
- wb_sel  out  1  1 = load data, 0 = ALU result.
- load_data  out  XLEN  latched dmem_rdata.
- state  out  STATE_W  FSM code.
- retire  out  1  one-cycle pulse per completed instruction.
- halted  out  1  sticky halt flag.

Behaviour:
- Reset (rst=0, asynchronous):
  - pc=RESET_PC; instr=0; state=FETCH; load_data=0.
  - imem_valid, dmem_valid, dmem_we, rd_wen, wb_sel, retire and halted all 0.
  - dmem_addr=0, dmem_wdata=0.
  - Reset mid-handshake aborts the transaction immediately.
  - FETCH is entered on the first edge after rst returns high.
- State codes: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- FETCH:
  - imem_valid=1 and imem_addr=pc.
  - On a cycle with imem_valid&imem_ready: IR<=imem_rdata, then go to DECODE.
  - With imem_ready low: hold state; valid and addr stay stable.
- DECODE: one cycle for regfile read, then go to EXEC.
- EXEC, exits in priority order:
  - dec_illegal=1 -> HALT.
  - dec_mem_read|dec_mem_write -> MEM. On this edge register dmem_addr<=alu_result, dmem_wdata<=rs2_data, dmem_we<=dec_mem_write.
  - dec_reg_write -> WB.
  - Otherwise retire directly (branch with no writeback), go to FETCH.
- MEM:
  - dmem_valid=1 until a cycle with dmem_ready=1.
  - On that cycle: a load latches load_data<=dmem_rdata and goes to WB; a store retires and goes to FETCH.
  - A stalled dmem holds all outputs stable.
- WB:
  - rd_wen=1 for exactly one cycle; wb_sel=dec_mem_read.
  - Retire, then go to FETCH.
- Retire edge:
  - retire=1 for one cycle.
  - pc <= target_pc if dec_jump | (dec_branch & branch_taken); otherwise pc+4.
  - PC arithmetic is modulo 2^XLEN: 32'hFFFF_FFFC+4 = 0.
- A redirect whose target_pc[1:0]!=0 does not retire. It goes to HALT with pc unchanged.
- HALT:
  - halted=1; no memory requests; rd_wen=0.
  - Left only through reset.
- rd_wen never asserts outside WB. A store or branch never writes the regfile.
- Minimum latency, memories ready immediately: ALU op 4 cycles, load 5, store 4, branch 3.

Optional Feature:
- Macro: MULTICYCLE_CORE_SEQ_PERF_EN.
- When defined:
  - Adds outputs perf_cycles and perf_instret, 64 bits each, reset to 0.
  - perf_cycles increments every cycle while not halted.
  - perf_instret increments on each retire pulse.
  - Both wrap at 2^64.
- When undefined: neither port exists and no counter logic is built.

Decomposition:
- Package core_pkg holds:
  - state enum state_e (FETCH..HALT);
  - RESET_PC default constant;
  - INSTR_W=32.
- The FSM, PC and IR stay in this module.
- Natural sub-module: mem_req_hold, a generic valid/ready request holder. Instantiate it once for imem and once for dmem.

Test Plan:
- Reset with RESET_PC=32'h100, imem always ready, fetch addi (reg_write) -> imem_addr=0x100, rd_wen pulses in cycle 4, pc=0x104, retire=1 once.
- Hold imem_ready low for 3 cycles -> state stays FETCH, imem_valid=1 and imem_addr stable throughout; IR captured on the ready cycle.
- Load with dmem_ready delayed 2 cycles, dmem_rdata=32'hDEAD_BEEF -> load_data=32'hDEAD_BEEF, wb_sel=1, rd_wen for one cycle, total 7 cycles.
- Store -> dmem_we=1, dmem_addr=alu_result, rd_wen never asserts, pc+=4 after 4 cycles.
- Branch taken, target_pc=0x200 -> pc=0x200. Then jump to 0x202 -> HALT, halted=1, pc unchanged, no further imem_valid.
- Assert rst low mid-MEM -> dmem_valid=0 immediately, pc=RESET_PC; after release a fresh fetch from RESET_PC. With MULTICYCLE_CORE_SEQ_PERF_EN, counters are back at 0.

Source files
------------

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared state encoding and constants for the multi-cycle core sequencer
package core_pkg;

    localparam int INSTR_W = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_e;

endpackage

// File: rtl/mem_req_hold.sv
// rtl/mem_req_hold.sv - valid/ready request holder that keeps valid up until ready and captures response data
module mem_req_hold #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         ready,
    input  logic         cap_en,
    input  logic [W-1:0] rdata,
    output logic         valid,
    output logic         fire,
    output logic [W-1:0] data
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    assign fire  = valid_q & ready;
    assign valid = valid_q;
    assign data  = data_q;

    always_comb begin
        valid_d = start | (valid_q & ~ready);
        data_d  = (fire & cap_en) ? rdata : data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/multicycle_core_seq.sv
// rtl/multicycle_core_seq.sv - FETCH/DECODE/EXEC/MEM/WB sequencer owning PC and IR
// Optional 64-bit cycle/instret counters under MULTICYCLE_CORE_SEQ_PERF_EN.
module multicycle_core_seq
    import core_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT),
    parameter int              STATE_W  = 3
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_valid,
    input  logic               imem_ready,
    output logic [XLEN-1:0]    imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic               dmem_valid,
    input  logic               dmem_ready,
    output logic               dmem_we,
    output logic [XLEN-1:0]    dmem_addr,
    output logic [XLEN-1:0]    dmem_wdata,
    input  logic [XLEN-1:0]    dmem_rdata,
    input  logic               dec_reg_write,
    input  logic               dec_mem_read,
    input  logic               dec_mem_write,
    input  logic               dec_branch,
    input  logic               dec_jump,
    input  logic               dec_illegal,
    input  logic               branch_taken,
    input  logic [XLEN-1:0]    target_pc,
    input  logic [XLEN-1:0]    alu_result,
    input  logic [XLEN-1:0]    rs2_data,
    output logic [XLEN-1:0]    pc,
    output logic [31:0]        instr,
    output logic               rd_wen,
    output logic               wb_sel,
    output logic [XLEN-1:0]    load_data,
    output logic [STATE_W-1:0] state,
`ifdef MULTICYCLE_CORE_SEQ_PERF_EN
    output logic [63:0]        perf_cycles,
    output logic [63:0]        perf_instret,
`endif
    output logic               retire,
    output logic               halted
);

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] dmem_addr_q, dmem_addr_d;
    logic [XLEN-1:0] dmem_wdata_q, dmem_wdata_d;
    logic            dmem_we_q, dmem_we_d;
    logic            rd_wen_q, rd_wen_d;
    logic            wb_sel_q, wb_sel_d;
    logic            retire_q, retire_d;
    logic            halted_q, halted_d;

    logic            imem_fire, dmem_fire;
    logic            imem_start, dmem_start;
    logic            retire_now, redirect, misaligned;

    mem_req_hold #(.W(INSTR_W)) u_imem_hold (
        .clk    (clk),
        .rst_n  (rst),
        .start  (imem_start),
        .ready  (imem_ready),
        .cap_en (1'b1),
        .rdata  (imem_rdata),
        .valid  (imem_valid),
        .fire   (imem_fire),
        .data   (instr)
    );

    mem_req_hold #(.W(XLEN)) u_dmem_hold (
        .clk    (clk),
        .rst_n  (rst),
        .start  (dmem_start),
        .ready  (dmem_ready),
        .cap_en (~dmem_we_q),
        .rdata  (dmem_rdata),
        .valid  (dmem_valid),
        .fire   (dmem_fire),
        .data   (load_data)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;
        dmem_we_d    = dmem_we_q;
        retire_now   = 1'b0;

        case (state_q)
            FETCH:  if (imem_fire) state_d = DECODE;
            DECODE: state_d = EXEC;
            EXEC: begin
                if (dec_illegal) begin
                    state_d = HALT;
                end else if (dec_mem_read || dec_mem_write) begin
                    state_d      = MEM;
                    dmem_addr_d  = alu_result;
                    dmem_wdata_d = rs2_data;
                    dmem_we_d    = dec_mem_write;
                end else if (dec_reg_write) begin
                    state_d = WB;
                end else begin
                    retire_now = 1'b1;
                end
            end
            MEM: begin
                if (dmem_fire) begin
                    if (dmem_we_q) retire_now = 1'b1;
                    else           state_d    = WB;
                end
            end
            WB:      retire_now = 1'b1;
            HALT:    state_d = HALT;
            default: state_d = HALT;
        endcase

        // A misaligned redirect is treated as a fault: no retire, PC frozen.
        redirect   = dec_jump | (dec_branch & branch_taken);
        misaligned = redirect & (target_pc[1:0] != 2'b00);
        if (retire_now) begin
            if (misaligned) begin
                state_d = HALT;
            end else begin
                state_d = FETCH;
                pc_d    = redirect ? target_pc : pc_q + XLEN'(4);
            end
        end

        retire_d = retire_now & ~misaligned;
        rd_wen_d = (state_d == WB);
        wb_sel_d = (state_d == WB) & dec_mem_read;
        halted_d = (state_d == HALT);

        // Raise fetch valid on entry to FETCH, including the first cycle out of reset.
        imem_start = (state_d == FETCH) && ((state_q != FETCH) || !imem_valid);
        dmem_start = (state_q == EXEC) && (state_d == MEM);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            dmem_we_q    <= 1'b0;
            rd_wen_q     <= 1'b0;
            wb_sel_q     <= 1'b0;
            retire_q     <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
            dmem_we_q    <= dmem_we_d;
            rd_wen_q     <= rd_wen_d;
            wb_sel_q     <= wb_sel_d;
            retire_q     <= retire_d;
            halted_q     <= halted_d;
        end
    end

`ifdef MULTICYCLE_CORE_SEQ_PERF_EN
    logic [63:0] perf_cycles_q, perf_cycles_d;
    logic [63:0] perf_instret_q, perf_instret_d;

    always_comb begin
        perf_cycles_d  = halted_q ? perf_cycles_q : perf_cycles_q + 64'd1;
        perf_instret_d = retire_q ? perf_instret_q + 64'd1 : perf_instret_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_cycles_q  <= '0;
            perf_instret_q <= '0;
        end else begin
            perf_cycles_q  <= perf_cycles_d;
            perf_instret_q <= perf_instret_d;
        end
    end

    assign perf_cycles  = perf_cycles_q;
    assign perf_instret = perf_instret_q;
`endif

    assign pc         = pc_q;
    assign imem_addr  = pc_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_wdata = dmem_wdata_q;
    assign dmem_we    = dmem_we_q;
    assign rd_wen     = rd_wen_q;
    assign wb_sel     = wb_sel_q;
    assign retire     = retire_q;
    assign halted     = halted_q;
    assign state      = STATE_W'(state_q);

endmodule
